// File: rtl/des_key_sched_ctrl_if.sv
// Key request and subkey stream bundle for the DES key-schedule sequencer.
// master = key source / subkey consumer, slave = the sequencer.
interface des_key_sched_ctrl_if;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        decrypt;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] sk;
  logic [4:0]  sk_round;
  logic        sk_last;

  modport master (
    output key_valid, key, decrypt, sk_ready,
    input  key_ready, sk_valid, sk, sk_round, sk_last
  );

  modport slave (
    input  key_valid, key, decrypt, sk_ready,
    output key_ready, sk_valid, sk, sk_round, sk_last
  );
endinterface

// File: rtl/des_key_sched_ctrl.sv
// Iterative DES key schedule: PC-1 on accept, one C/D shift per round, PC-2 subkey per handshake.
// Decrypt walks K16..K1 by rotating right from C0/D0, so no subkey storage is needed.
//
// state | meaning
// IDLE  | key_ready high, waiting for a key (parity rejects stay here)
// EMIT  | offering subkey for the current round, holding it under backpressure
module des_key_sched_ctrl #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  des_key_sched_ctrl_if.slave         bus,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        par_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Table entries use DES numbering: bit 1 is the MSB of the source vector.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
  function automatic logic single_shift(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
  endfunction

  state_t      state, state_nxt;
  logic [27:0] c, c_nxt;
  logic [27:0] d, d_nxt;
  logic [4:0]  round, round_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        dec, dec_nxt;
  logic [47:0] sk_r, sk_nxt;
  logic        done_r, done_nxt;
  logic        par_err_r, par_err_nxt;
  logic [55:0] cd0;
  logic [7:0]  byte_par;
  logic        key_par_ok;

  always_comb begin
    byte_par = '0;
    for (int b = 0; b < 8; b++) byte_par[b] = ^bus.key[8*b +: 8];
    key_par_ok = &byte_par;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      c         <= '0;
      d         <= '0;
      round     <= '0;
      cnt       <= '0;
      dec       <= 1'b0;
      sk_r      <= '0;
      done_r    <= 1'b0;
      par_err_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      c         <= c_nxt;
      d         <= d_nxt;
      round     <= round_nxt;
      cnt       <= cnt_nxt;
      dec       <= dec_nxt;
      sk_r      <= sk_nxt;
      done_r    <= done_nxt;
      par_err_r <= par_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    c_nxt       = c;
    d_nxt       = d;
    round_nxt   = round;
    cnt_nxt     = cnt;
    dec_nxt     = dec;
    done_nxt    = 1'b0;
    par_err_nxt = 1'b0;
    cd0         = pc1(bus.key);

    case (state)
      IDLE: begin
        if (bus.key_valid) begin
          if (CHECK_PARITY && !key_par_ok) begin
            par_err_nxt = 1'b1;
          end else begin
            state_nxt = EMIT;
            dec_nxt   = bus.decrypt;
            cnt_nxt   = 4'd0;
            // Decrypt starts from C0/D0: the 16 shifts total 28, i.e. C16 == C0.
            if (bus.decrypt) begin
              c_nxt     = cd0[55:28];
              d_nxt     = cd0[27:0];
              round_nxt = 5'd16;
            end else begin
              c_nxt     = rotl(cd0[55:28], 1'b0);
              d_nxt     = rotl(cd0[27:0], 1'b0);
              round_nxt = 5'd1;
            end
          end
        end
      end

      EMIT: begin
        if (abort) begin
          state_nxt = IDLE;
          round_nxt = 5'd0;
          cnt_nxt   = 4'd0;
        end else if (bus.sk_ready) begin
          if (cnt == 4'd15) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            round_nxt = 5'd0;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
            if (dec) begin
              c_nxt     = rotr(c, !single_shift(round));
              d_nxt     = rotr(d, !single_shift(round));
              round_nxt = round - 5'd1;
            end else begin
              c_nxt     = rotl(c, !single_shift(round + 5'd1));
              d_nxt     = rotl(d, !single_shift(round + 5'd1));
              round_nxt = round + 5'd1;
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Stall keeps c/d unchanged, so the registered subkey holds as well.
    sk_nxt = (state_nxt == EMIT) ? pc2({c_nxt, d_nxt}) : '0;
  end

  assign bus.key_ready = (state == IDLE);
  assign bus.sk_valid  = (state == EMIT);
  assign bus.sk        = sk_r;
  assign bus.sk_round  = round;
  assign bus.sk_last   = (state == EMIT) && (cnt == 4'd15);
  assign busy          = (state == EMIT);
  assign done          = done_r;
  assign par_err       = par_err_r;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl: scoreboard of expected subkeys from a reference key schedule.
module tb_des_key_sched_ctrl;

  localparam logic [63:0] GOLD_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] BAD_KEY  = 64'h133457799BBCDFF0;
  localparam logic [63:0] ALT_KEY  = 64'h0123456789ABCDEF;
  localparam logic [47:0] GOLD_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] GOLD_K16 = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic [47:0] sk;
    logic [4:0]  rnd;
    logic        last;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic busy, done, par_err;

  des_key_sched_ctrl_if bus_if ();

  des_key_sched_ctrl #(.CHECK_PARITY(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .par_err (par_err)
  );

  always #5 clk = ~clk;

  entry_t exp_q [$];
  entry_t obs_q [$];
  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int done_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Cumulative-shift reference: Ki = PC-2(rotl^(S1+..+Si)(PC-1(key))).
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int i);
    logic [55:0] cd;
    logic [27:0] ch, dh;
    logic [47:0] r;
    int sh;
    cd = '0;
    r  = '0;
    for (int j = 0; j < 56; j++) cd[55-j] = k[64-PC1[j]];
    ch = cd[55:28];
    dh = cd[27:0];
    sh = 0;
    for (int j = 0; j < i; j++) sh += SHIFTS[j];
    for (int j = 0; j < sh; j++) begin
      ch = {ch[26:0], ch[27]};
      dh = {dh[26:0], dh[27]};
    end
    cd = {ch, dh};
    for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
    return r;
  endfunction

  function automatic logic parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) if (!(^k[8*b +: 8])) ok = 1'b0;
    return ok;
  endfunction

  task automatic push_sched(input logic [63:0] k, input logic dec);
    entry_t e;
    int rnd;
    for (int n = 0; n < 16; n++) begin
      rnd    = dec ? 16 - n : n + 1;
      e.sk   = ref_subkey(k, rnd);
      e.rnd  = 5'(rnd);
      e.last = (n == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_key(input logic [63:0] k, input logic dec);
    chk("key_ready_before_accept", 64'(bus_if.key_ready), 64'd1);
    bus_if.key_valid = 1'b1;
    bus_if.key       = k;
    bus_if.decrypt   = dec;
    if (parity_ok(k)) push_sched(k, dec);
    @(posedge clk); #1;
    bus_if.key_valid = 1'b0;
    chk("accept_latency_valid", 64'(bus_if.sk_valid), 64'(parity_ok(k)));
    if (parity_ok(k)) chk("accept_first_round", 64'(bus_if.sk_round), dec ? 64'd16 : 64'd1);
  endtask

  task automatic wait_done(input int budget, input logic random_ready);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (random_ready && !done) bus_if.sk_ready = 1'($urandom_range(0, 1));
    end
    chk("done_within_budget", 64'(done), 64'd1);
    chk("done_key_ready", 64'(bus_if.key_ready), 64'd1);
    chk("done_sk_valid_low", 64'(bus_if.sk_valid), 64'd0);
    bus_if.sk_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, 64'(bus_if.key_ready), 64'd1);
    chk({tag, "_sk_valid"},  64'(bus_if.sk_valid), 64'd0);
    chk({tag, "_sk"},        64'(bus_if.sk), 64'd0);
    chk({tag, "_sk_round"},  64'(bus_if.sk_round), 64'd0);
    chk({tag, "_sk_last"},   64'(bus_if.sk_last), 64'd0);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_done"},      64'(done), 64'd0);
    chk({tag, "_par_err"},   64'(par_err), 64'd0);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold-under-stall.
  initial begin
    entry_t e;
    entry_t o;
    logic stalled_prev;
    logic [47:0] sk_prev;
    logic [4:0] rnd_prev;
    stalled_prev = 1'b0;
    sk_prev = '0;
    rnd_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled_prev = 1'b0;
      end else begin
        if (bus_if.sk_valid) valid_cycles++;
        if (done) done_pulses++;
        if (stalled_prev && bus_if.sk_valid) begin
          chk("stall_hold_sk", 64'(bus_if.sk), 64'(sk_prev));
          chk("stall_hold_round", 64'(bus_if.sk_round), 64'(rnd_prev));
        end
        if (bus_if.sk_valid && bus_if.sk_ready) begin
          o.sk = bus_if.sk;
          o.rnd = bus_if.sk_round;
          o.last = bus_if.sk_last;
          obs_q.push_back(o);
          chk("sb_has_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_sk", 64'(o.sk), 64'(e.sk));
            chk("sb_round", 64'(o.rnd), 64'(e.rnd));
            chk("sb_last", 64'(o.last), 64'(e.last));
          end
        end
        stalled_prev = bus_if.sk_valid && !bus_if.sk_ready;
        sk_prev = bus_if.sk;
        rnd_prev = bus_if.sk_round;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, vbase, dbase, n;
    rst = 1'b1;
    abort = 1'b0;
    bus_if.key_valid = 1'b0;
    bus_if.key = '0;
    bus_if.decrypt = 1'b0;
    bus_if.sk_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Encrypt, no backpressure
    bus_if.sk_ready = 1'b1;
    base = obs_q.size(); vbase = valid_cycles; dbase = done_pulses;
    start_key(GOLD_KEY, 1'b0);
    wait_done(40, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("enc_valid_cycles", 64'(valid_cycles - vbase), 64'd16);
    chk("enc_done_pulses", 64'(done_pulses - dbase), 64'd1);
    chk("enc_first_k1", 64'(obs_q[base].sk), 64'(GOLD_K1));
    chk("enc_last_k16", 64'(obs_q[base+15].sk), 64'(GOLD_K16));
    chk("enc_last_round", 64'(obs_q[base+15].rnd), 64'd16);
    chk("enc_last_flag", 64'(obs_q[base+15].last), 64'd1);

    // Decrypt: K16 first, K1 last
    base = obs_q.size();
    start_key(GOLD_KEY, 1'b1);
    wait_done(40, 1'b0);
    chk("dec_first_k16", 64'(obs_q[base].sk), 64'(GOLD_K16));
    chk("dec_first_round", 64'(obs_q[base].rnd), 64'd16);
    chk("dec_last_k1", 64'(obs_q[base+15].sk), 64'(GOLD_K1));
    chk("dec_last_round", 64'(obs_q[base+15].rnd), 64'd1);

    // Encrypt with random backpressure
    base = obs_q.size();
    bus_if.sk_ready = 1'($urandom_range(0, 1));
    start_key(GOLD_KEY, 1'b0);
    bus_if.sk_ready = 1'($urandom_range(0, 1));
    wait_done(400, 1'b1);
    chk("stall_handshakes", 64'(obs_q.size() - base), 64'd16);
    chk("stall_sb_drained", 64'(exp_q.size()), 64'd0);

    // Abort on the 5th valid cycle
    bus_if.sk_ready = 1'b1;
    start_key(GOLD_KEY, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_at_round5", 64'(bus_if.sk_round), 64'd5);
    abort = 1'b1;
    dbase = done_pulses;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_sk_valid", 64'(bus_if.sk_valid), 64'd0);
    chk("abort_key_ready", 64'(bus_if.key_ready), 64'd1);
    chk("abort_sk_round", 64'(bus_if.sk_round), 64'd0);
    chk("abort_sk_last", 64'(bus_if.sk_last), 64'd0);
    chk("abort_remaining", 64'(exp_q.size()), 64'd11);
    exp_q.delete();
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_no_done", 64'(done_pulses - dbase), 64'd0);
    // abort held in IDLE must not block the accept
    base = obs_q.size();
    abort = 1'b1;
    start_key(GOLD_KEY, 1'b0);
    abort = 1'b0;
    wait_done(40, 1'b0);
    chk("restart_k1", 64'(obs_q[base].sk), 64'(GOLD_K1));

    // Parity reject, then a good-parity key
    vbase = valid_cycles;
    start_key(BAD_KEY, 1'b0);
    chk("parity_err_pulse", 64'(par_err), 64'd1);
    chk("parity_key_ready", 64'(bus_if.key_ready), 64'd1);
    @(posedge clk); #1;
    chk("parity_err_clears", 64'(par_err), 64'd0);
    chk("parity_no_valid", 64'(valid_cycles - vbase), 64'd0);
    start_key(ALT_KEY, 1'b0);
    wait_done(40, 1'b0);
    chk("alt_sb_drained", 64'(exp_q.size()), 64'd0);

    // Reset during a stall
    bus_if.sk_ready = 1'b0;
    start_key(GOLD_KEY, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    chk("midrst_pending", 64'(exp_q.size()), 64'd16);
    exp_q.delete();

    // Back-to-back keys: next key offered before done, accepted in the done cycle
    bus_if.sk_ready = 1'b1;
    start_key(GOLD_KEY, 1'b0);
    n = 0;
    while (!bus_if.sk_last && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_last_seen", 64'(bus_if.sk_last), 64'd1);
    bus_if.key_valid = 1'b1;
    bus_if.key = ALT_KEY;
    bus_if.decrypt = 1'b1;
    push_sched(ALT_KEY, 1'b1);
    @(posedge clk); #1;
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_key_ready", 64'(bus_if.key_ready), 64'd1);
    @(posedge clk); #1;
    bus_if.key_valid = 1'b0;
    chk("b2b_zero_gap_valid", 64'(bus_if.sk_valid), 64'd1);
    chk("b2b_round16", 64'(bus_if.sk_round), 64'd16);
    wait_done(40, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk("final_sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
